// File: rtl/m_ram_sync.sv
// Single-port synchronous word RAM with request handshake, byte-lane writes,
// registered one-cycle read and an optional zero-fill sweep after reset.
module m_ram_sync #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic                    ready,
  output logic                    rvalid,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    init_busy
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [ADDR_WIDTH-1:0]   cnt_next;
  logic                    ready_next;
  logic                    busy_next;

  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [NUM_BYTES-1:0]    wr_be;
  logic                    rd_en;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Control registers; reset picks the fill sweep or goes straight to normal operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      cnt       <= '0;
      ready     <= 1'b0;
      init_busy <= CLEAR_ON_RESET;
      rvalid    <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      ready     <= ready_next;
      init_busy <= busy_next;
      rvalid    <= rd_en;
    end
  end

  // Next-state logic and selection of the single RAM write port (fill sweep vs. user write)
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ready_next = ready;
    busy_next  = init_busy;
    wr_en      = 1'b0;
    wr_addr    = address;
    wr_data    = data_in;
    wr_be      = be;
    rd_en      = 1'b0;
    case (state)
      ST_CLEAR: begin
        wr_en      = 1'b1;
        wr_addr    = cnt;
        wr_data    = '0;
        wr_be      = '1;
        cnt_next   = cnt + 1'b1;
        ready_next = 1'b0;
        busy_next  = 1'b1;
        if (cnt == {ADDR_WIDTH{1'b1}}) begin
          state_next = ST_RUN;
          busy_next  = 1'b0;
          ready_next = 1'b1;
        end
      end
      ST_RUN: begin
        ready_next = 1'b1;
        busy_next  = 1'b0;
        if (ready && req) begin
          if (we) begin
            wr_en = 1'b1;
          end else begin
            rd_en = 1'b1;
          end
        end
      end
    endcase
  end

  // Storage array; reset never touches contents, only the sweep or a user write does
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Registered read data; holds its value until the next accepted read
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
    end else if (rd_en) begin
      data_out <= mem[address];
    end
  end

endmodule

// File: tb/tb_m_ram_sync.sv
// Bench for m_ram_sync: one instance with zero-fill, one without, checked against an array model.
module tb_m_ram_sync;

  logic        clk;
  logic        reset, req, we;
  logic [3:0]  be;
  logic [3:0]  address;
  logic [31:0] data_in;
  logic        ready, rvalid, init_busy;
  logic [31:0] data_out;

  logic        reset0, req0, we0;
  logic [3:0]  be0;
  logic [3:0]  address0;
  logic [31:0] data_in0;
  logic        ready0, rvalid0, init_busy0;
  logic [31:0] data_out0;

  int          checks;
  int          errors;
  logic [31:0] model [16];
  logic [31:0] exp_dout;
  logic [31:0] tmp;

  m_ram_sync #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .be(be), .address(address),
    .data_in(data_in), .ready(ready), .rvalid(rvalid), .data_out(data_out),
    .init_busy(init_busy)
  );

  m_ram_sync #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .CLEAR_ON_RESET(1'b0)) dut0 (
    .clk(clk), .reset(reset0), .req(req0), .we(we0), .be(be0), .address(address0),
    .data_in(data_in0), .ready(ready0), .rvalid(rvalid0), .data_out(data_out0),
    .init_busy(init_busy0)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of traffic on the zero-fill instance, then compare against the array model
  task automatic apply_stimulus(input logic rq, input logic w, input logic [3:0] b,
                                input logic [3:0] a, input logic [31:0] d, input string tag);
    logic exp_rvalid;
    req = rq; we = w; be = b; address = a; data_in = d;
    tick();
    exp_rvalid = rq && !w;
    if (exp_rvalid) exp_dout = model[a];
    if (rq && w) begin
      for (int i = 0; i < 4; i++) begin
        if (b[i]) model[a][8*i +: 8] = d[8*i +: 8];
      end
    end
    check_output({tag, "_ready"}, {31'b0, ready}, 32'd1);
    check_output({tag, "_rvalid"}, {31'b0, rvalid}, {31'b0, exp_rvalid});
    check_output({tag, "_data"}, data_out, exp_dout);
  endtask

  // Measure the sweep length while hammering writes that must be ignored
  task automatic wait_fill(input string tag);
    int n;
    int ready_bad;
    n = 0;
    ready_bad = 0;
    while (init_busy === 1'b1 && n < 100) begin
      if (ready !== 1'b0) ready_bad++;
      req = 1'b1; we = 1'b1; be = 4'hF; address = 4'h0; data_in = $urandom;
      tick();
      n++;
    end
    req = 1'b0;
    check_output({tag, "_fill_cycles"}, n, 32'd16);
    check_output({tag, "_ready_during_fill"}, ready_bad, 32'd0);
    check_output({tag, "_ready_after_fill"}, {31'b0, ready}, 32'd1);
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
  endtask

  initial begin
    clk = 1'b0;
    checks = 0;
    errors = 0;
    exp_dout = 32'h0;
    reset = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0; address = 4'h0; data_in = 32'h0;
    reset0 = 1'b1; req0 = 1'b0; we0 = 1'b0; be0 = 4'h0; address0 = 4'h0; data_in0 = 32'h0;

    $display("[TB] zero-fill after a one-cycle reset");
    tick();
    reset = 1'b0;
    check_output("rst_ready", {31'b0, ready}, 32'd0);
    check_output("rst_busy", {31'b0, init_busy}, 32'd1);
    check_output("rst_rvalid", {31'b0, rvalid}, 32'd0);
    check_output("rst_data", data_out, 32'h0);
    wait_fill("fill1");
    for (int i = 0; i < 16; i++) apply_stimulus(1'b1, 1'b0, 4'h0, 4'(i), 32'h0, "zero_read");

    $display("[TB] directed byte-lane writes");
    apply_stimulus(1'b1, 1'b1, 4'hF, 4'h3, 32'hDEADBEEF, "wr_full");
    apply_stimulus(1'b1, 1'b0, 4'h0, 4'h3, 32'h0, "rd_full");
    check_output("rd_full_const", data_out, 32'hDEADBEEF);
    apply_stimulus(1'b1, 1'b1, 4'b0101, 4'h3, 32'h11223344, "wr_merge");
    apply_stimulus(1'b1, 1'b0, 4'h0, 4'h3, 32'h0, "rd_merge");
    check_output("rd_merge_const", data_out, 32'hDE22BE44);
    apply_stimulus(1'b1, 1'b1, 4'h0, 4'h3, 32'hFFFFFFFF, "wr_be0");
    apply_stimulus(1'b1, 1'b0, 4'hF, 4'h3, 32'h0, "rd_be0");
    check_output("rd_be0_const", data_out, 32'hDE22BE44);

    $display("[TB] back-to-back reads");
    apply_stimulus(1'b1, 1'b1, 4'hF, 4'h1, 32'hA, "wr_a");
    apply_stimulus(1'b1, 1'b1, 4'hF, 4'h2, 32'hB, "wr_b");
    apply_stimulus(1'b1, 1'b1, 4'hF, 4'h3, 32'hC, "wr_c");
    apply_stimulus(1'b1, 1'b0, 4'h0, 4'h1, 32'h0, "b2b_1");
    apply_stimulus(1'b1, 1'b0, 4'h0, 4'h2, 32'h0, "b2b_2");
    apply_stimulus(1'b1, 1'b0, 4'h0, 4'h3, 32'h0, "b2b_3");
    apply_stimulus(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, "b2b_idle");
    check_output("b2b_hold_const", data_out, 32'hC);

    $display("[TB] random traffic");
    for (int k = 0; k < 300; k++) begin
      tmp = $urandom;
      apply_stimulus(tmp[0], tmp[1], tmp[5:2], tmp[9:6], $urandom, "rand");
    end
    for (int i = 0; i < 16; i++) apply_stimulus(1'b1, 1'b1, 4'hF, 4'(i), $urandom | 32'h1, "fillpat");

    $display("[TB] reset during run drops pending read");
    apply_stimulus(1'b1, 1'b0, 4'h0, 4'h5, 32'h0, "pre_rst_rd");
    reset = 1'b1; req = 1'b1; we = 1'b0; address = 4'h5;
    tick();
    check_output("run_rst_rvalid", {31'b0, rvalid}, 32'd0);
    check_output("run_rst_data", data_out, 32'h0);
    check_output("run_rst_busy", {31'b0, init_busy}, 32'd1);
    exp_dout = 32'h0;

    $display("[TB] reset in the middle of the fill");
    reset = 1'b0; req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_fill("fill2");
    for (int i = 0; i < 16; i++) apply_stimulus(1'b1, 1'b0, 4'h0, 4'(i), 32'h0, "refill_read");

    $display("[TB] instance without zero-fill");
    reset0 = 1'b1; req0 = 1'b1; we0 = 1'b0; address0 = 4'h5;
    tick();
    check_output("nf_rst_rvalid", {31'b0, rvalid0}, 32'd0);
    check_output("nf_rst_data", data_out0, 32'h0);
    check_output("nf_rst_ready", {31'b0, ready0}, 32'd0);
    check_output("nf_rst_busy", {31'b0, init_busy0}, 32'd0);
    reset0 = 1'b0; req0 = 1'b0;
    tick();
    check_output("nf_ready", {31'b0, ready0}, 32'd1);
    tmp = $urandom;
    req0 = 1'b1; we0 = 1'b1; be0 = 4'hF; address0 = 4'h5; data_in0 = tmp;
    tick();
    check_output("nf_wr_rvalid", {31'b0, rvalid0}, 32'd0);
    we0 = 1'b0;
    tick();
    check_output("nf_rd_rvalid", {31'b0, rvalid0}, 32'd1);
    check_output("nf_rd_data", data_out0, tmp);
    reset0 = 1'b1;
    tick();
    check_output("nf_midrst_rvalid", {31'b0, rvalid0}, 32'd0);
    check_output("nf_midrst_data", data_out0, 32'h0);
    reset0 = 1'b0; req0 = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
